// File: rtl/bank_cmd_arbiter.sv
// Round-robin DRAM command arbiter. It enforces per-bank timing (tRCD, tRP, tRAS, tWR) and cross-bank timing (tCCD, tRRD).
// Latency: the grant is combinational and the command bus is registered, so a grant in cycle t appears on the bus in cycle t+1.
// Backpressure: any bank that requests but is not granted sees stall in the same cycle and holds its request.
module bank_cmd_arbiter #(
    parameter int NB     = 8,
    parameter int ADDR_W = 16,
    parameter int TRCD   = 4,
    parameter int TRP    = 4,
    parameter int TRAS   = 10,
    parameter int TWR    = 5,
    parameter int TCCD   = 2,
    parameter int TRRD   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NB-1:0]           req_valid,
    input  logic [3*NB-1:0]         req_cmd,
    input  logic [ADDR_W*NB-1:0]    req_addr,
    output logic [NB-1:0]           stall,
    output logic                    cmd_valid,
    output logic [2:0]              cmd_type,
    output logic [$clog2(NB)-1:0]   cmd_bank,
    output logic [ADDR_W-1:0]       cmd_addr,
    output logic [15:0]             grant_cnt
);
    localparam int BW = $clog2(NB);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    // Loading T-1 makes the next grant land exactly T cycles after this one.
    localparam logic [5:0] LD_RCD = 6'(TRCD - 1);
    localparam logic [5:0] LD_RP  = 6'(TRP - 1);
    localparam logic [5:0] LD_RAS = 6'(TRAS - 1);
    localparam logic [5:0] LD_WR  = 6'(TWR - 1);
    localparam logic [5:0] LD_CCD = 6'(TCCD - 1);
    localparam logic [5:0] LD_RRD = 6'(TRRD - 1);

    logic [2:0]        cmd_a  [NB];
    logic [ADDR_W-1:0] addr_a [NB];

    logic [5:0] c_rcd_q [NB];
    logic [5:0] c_rcd_d [NB];
    logic [5:0] c_rp_q  [NB];
    logic [5:0] c_rp_d  [NB];
    logic [5:0] c_ras_q [NB];
    logic [5:0] c_ras_d [NB];
    logic [5:0] c_wr_q  [NB];
    logic [5:0] c_wr_d  [NB];
    logic [5:0] c_ccd_q, c_ccd_d;
    logic [5:0] c_rrd_q, c_rrd_d;

    logic [BW-1:0]     rr_q, rr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [2:0]        cmd_type_q, cmd_type_d;
    logic [BW-1:0]     cmd_bank_q, cmd_bank_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [15:0]       grant_cnt_q, grant_cnt_d;

    logic [NB-1:0] active;
    logic [NB-1:0] elig;
    logic [NB-1:0] gnt_oh;
    logic          gnt_vld;
    logic [BW-1:0] gnt_idx;
    logic [BW-1:0] scan_idx;

    function automatic logic [5:0] dec_sat(input logic [5:0] c);
        return (c == 6'd0) ? 6'd0 : c - 6'd1;
    endfunction

    always_comb begin : decode
        for (int b = 0; b < NB; b++) begin
            cmd_a[b]  = req_cmd[3*b +: 3];
            addr_a[b] = req_addr[ADDR_W*b +: ADDR_W];
            active[b] = 1'b0;
            elig[b]   = 1'b0;
            if (req_valid[b]) begin
                case (cmd_a[b])
                    CMD_ACT: begin
                        active[b] = 1'b1;
                        elig[b]   = (c_rp_q[b] == 6'd0) && (c_rrd_q == 6'd0);
                    end
                    CMD_RD, CMD_WR: begin
                        active[b] = 1'b1;
                        elig[b]   = (c_rcd_q[b] == 6'd0) && (c_ccd_q == 6'd0);
                    end
                    CMD_PRE: begin
                        active[b] = 1'b1;
                        elig[b]   = (c_ras_q[b] == 6'd0) && (c_wr_q[b] == 6'd0);
                    end
                    CMD_REF: begin
                        active[b] = 1'b1;
                        elig[b]   = (c_rp_q[b] == 6'd0);
                    end
                    default: begin
                        active[b] = 1'b0;
                        elig[b]   = 1'b0;
                    end
                endcase
            end
        end
    end

    // Scan from rr upward; the power-of-2 bank count lets the index wrap naturally.
    always_comb begin : arbitrate
        gnt_vld  = 1'b0;
        gnt_idx  = rr_q;
        scan_idx = rr_q;
        gnt_oh   = '0;
        for (int i = 0; i < NB; i++) begin
            scan_idx = rr_q + BW'(i);
            if (!gnt_vld && elig[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign stall = active & ~gnt_oh;

    always_comb begin : next_state
        for (int b = 0; b < NB; b++) begin
            c_rcd_d[b] = dec_sat(c_rcd_q[b]);
            c_rp_d[b]  = dec_sat(c_rp_q[b]);
            c_ras_d[b] = dec_sat(c_ras_q[b]);
            c_wr_d[b]  = dec_sat(c_wr_q[b]);
        end
        c_ccd_d     = dec_sat(c_ccd_q);
        c_rrd_d     = dec_sat(c_rrd_q);
        rr_d        = rr_q;
        cmd_valid_d = 1'b0;
        cmd_type_d  = CMD_NOP;
        cmd_bank_d  = cmd_bank_q;
        cmd_addr_d  = cmd_addr_q;
        grant_cnt_d = grant_cnt_q;
        if (gnt_vld) begin
            rr_d        = gnt_idx + BW'(1);
            cmd_valid_d = 1'b1;
            cmd_type_d  = cmd_a[gnt_idx];
            cmd_bank_d  = gnt_idx;
            cmd_addr_d  = addr_a[gnt_idx];
            grant_cnt_d = grant_cnt_q + 16'd1;
            case (cmd_a[gnt_idx])
                CMD_ACT: begin
                    c_rcd_d[gnt_idx] = LD_RCD;
                    c_ras_d[gnt_idx] = LD_RAS;
                    c_rrd_d          = LD_RRD;
                end
                CMD_RD: c_ccd_d = LD_CCD;
                CMD_WR: begin
                    c_ccd_d         = LD_CCD;
                    c_wr_d[gnt_idx] = LD_WR;
                end
                CMD_PRE, CMD_REF: c_rp_d[gnt_idx] = LD_RP;
                default: c_ccd_d = c_ccd_d;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) begin
                c_rcd_q[b] <= '0;
                c_rp_q[b]  <= '0;
                c_ras_q[b] <= '0;
                c_wr_q[b]  <= '0;
            end
            c_ccd_q     <= '0;
            c_rrd_q     <= '0;
            rr_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_NOP;
            cmd_bank_q  <= '0;
            cmd_addr_q  <= '0;
            grant_cnt_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                c_rcd_q[b] <= c_rcd_d[b];
                c_rp_q[b]  <= c_rp_d[b];
                c_ras_q[b] <= c_ras_d[b];
                c_wr_q[b]  <= c_wr_d[b];
            end
            c_ccd_q     <= c_ccd_d;
            c_rrd_q     <= c_rrd_d;
            rr_q        <= rr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_addr_q  <= cmd_addr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_bank  = cmd_bank_q;
    assign cmd_addr  = cmd_addr_q;
    assign grant_cnt = grant_cnt_q;

endmodule
